// File: rtl/data_mem_responder_pkg.sv
// Shared types and widths for the data-memory responder and its access timer.
// State encoding is fixed so that traces line up with the CPU-side debug views.
package data_mem_responder_pkg;

  localparam int ADDR_W     = 8;
  localparam int DATA_W     = 8;
  localparam int DEPTH_DEF  = 256;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  typedef struct packed {
    logic              is_wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  // Latency value loaded into the timer; ACCESS lasts (value + 1) cycles.
  function automatic logic [CNT_W-1:0] access_load_val(input int access_cycles);
    return CNT_W'(access_cycles - 1);
  endfunction

endpackage

// File: rtl/data_mem_responder_timer.sv
// Down-counter that paces one memory access; expire_o is high while the count is zero.
// Loading takes priority over enable; the count never wraps because it only decrements when nonzero.
module mem_access_timer
  import data_mem_responder_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] count_i,
  output logic             expire_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = count_i;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire_o = (count_q == '0);

endmodule

// File: rtl/data_mem_responder.sv
// Byte-wide data memory serving CPU loads/stores with a fixed multi-cycle stall.
// Request is latched in IDLE, committed when the timer expires, then a one-cycle DONE absorbs held request lines.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int ACCESS_CYCLES = 5,
  parameter int DEPTH         = DEPTH_DEF
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              READ,
  input  logic              WRITE,
  input  logic [ADDR_W-1:0] ADDRESS,
  input  logic [DATA_W-1:0] WRITEDATA,
  output logic [DATA_W-1:0] READDATA,
  output logic              BUSYWAIT
);

  localparam logic [CNT_W-1:0] LOAD_VAL = access_load_val(ACCESS_CYCLES);

  state_t            state_q;
  req_t              req_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic req_vld;
  logic timer_load;
  logic timer_en;
  logic timer_expire;

  assign req_vld    = READ | WRITE;
  assign timer_load = (state_q == ST_IDLE) && req_vld;
  assign timer_en   = (state_q == ST_ACCESS);

  mem_access_timer u_timer (
    .clk_i    (CLK),
    .rst_ni   (RESET),
    .load_i   (timer_load),
    .en_i     (timer_en),
    .count_i  (LOAD_VAL),
    .expire_o (timer_expire)
  );

  // Stall rises in the same cycle as the request so the CPU never runs ahead of the access.
  always_comb begin
    BUSYWAIT = 1'b0;
    case (state_q)
      ST_IDLE:   BUSYWAIT = req_vld;
      ST_ACCESS: BUSYWAIT = 1'b1;
      default:   BUSYWAIT = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      rdata_q <= '0;
      mem_q   <= '{default: '0};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_vld) begin
            // A simultaneous read+write is resolved as a write.
            req_q.is_wr <= WRITE;
            req_q.addr  <= ADDRESS;
            req_q.wdata <= WRITEDATA;
            state_q     <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (timer_expire) begin
            if (req_q.is_wr) begin
              mem_q[req_q.addr] <= req_q.wdata;
            end else begin
              rdata_q <= mem_q[req_q.addr];
            end
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign READDATA = rdata_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Table-driven bench with a scoreboard queue for the data-memory responder.
module tb_data_mem_responder;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       READ;
  logic       WRITE;
  logic [7:0] ADDRESS;
  logic [7:0] WRITEDATA;
  logic [7:0] READDATA;
  logic       BUSYWAIT;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] mem_m [256];
  logic [7:0] rdata_m;
  logic [7:0] sb [$];

  typedef struct {
    logic       rd;
    logic       wr;
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] exp;
    bit         chg;
    bit         hold;
    string      name;
  } vec_t;

  vec_t tbl [12];

  data_mem_responder #(.ACCESS_CYCLES(5), .DEPTH(256)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .READ      (READ),
    .WRITE     (WRITE),
    .ADDRESS   (ADDRESS),
    .WRITEDATA (WRITEDATA),
    .READDATA  (READDATA),
    .BUSYWAIT  (BUSYWAIT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) mem_m[i] = 8'h00;
    rdata_m = 8'h00;
  endtask

  // Entered just after a rising edge with the DUT in IDLE; leaves it the same way.
  task automatic run_access(input vec_t v);
    int         stall;
    bit         done;
    logic [7:0] exp_q;
    if (v.wr) mem_m[v.a] = v.d;
    else      rdata_m = mem_m[v.a];
    sb.push_back(rdata_m);
    READ = v.rd; WRITE = v.wr; ADDRESS = v.a; WRITEDATA = v.d;
    stall = 0;
    done  = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge CLK);
      if (BUSYWAIT === 1'b1) begin
        stall++;
        @(posedge CLK); #1;
        if (v.chg) begin
          ADDRESS   = v.a + 8'h01;
          WRITEDATA = ~v.d;
        end
      end else begin
        done = 1;
      end
    end
    chk({v.name, " stall"}, stall, 6);
    exp_q = sb.pop_front();
    chk({v.name, " rdata"}, READDATA, exp_q);
    chk({v.name, " table"}, READDATA, v.exp);
    if (v.hold) begin
      @(posedge CLK); #1;
      chk({v.name, " rearm"}, BUSYWAIT, 1);
      READ = 1'b0; WRITE = 1'b0;
      #1;
      chk({v.name, " drop"}, BUSYWAIT, 0);
      @(posedge CLK); #1;
    end else begin
      READ = 1'b0; WRITE = 1'b0;
      @(posedge CLK); #1;
    end
  endtask

  initial begin
    vec_t rv;
    tbl[0]  = '{1'b0, 1'b1, 8'h10, 8'hA5, 8'h00, 1'b0, 1'b0, "wr10"};
    tbl[1]  = '{1'b1, 1'b0, 8'h20, 8'h00, 8'h00, 1'b0, 1'b0, "rd20"};
    tbl[2]  = '{1'b1, 1'b0, 8'h10, 8'h00, 8'hA5, 1'b0, 1'b0, "rd10"};
    tbl[3]  = '{1'b0, 1'b1, 8'h10, 8'h3C, 8'hA5, 1'b1, 1'b0, "wr10chg"};
    tbl[4]  = '{1'b1, 1'b0, 8'h11, 8'h00, 8'h00, 1'b0, 1'b0, "rd11"};
    tbl[5]  = '{1'b1, 1'b0, 8'h10, 8'h00, 8'h3C, 1'b0, 1'b0, "rd10b"};
    tbl[6]  = '{1'b1, 1'b1, 8'h05, 8'h77, 8'h3C, 1'b0, 1'b0, "rdwr05"};
    tbl[7]  = '{1'b1, 1'b0, 8'h05, 8'h00, 8'h77, 1'b0, 1'b0, "rd05"};
    tbl[8]  = '{1'b0, 1'b1, 8'hFF, 8'h5A, 8'h77, 1'b0, 1'b0, "wrFF"};
    tbl[9]  = '{1'b1, 1'b0, 8'hFF, 8'h00, 8'h5A, 1'b0, 1'b0, "rdFF"};
    tbl[10] = '{1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, "rd00"};
    tbl[11] = '{1'b1, 1'b0, 8'h10, 8'h00, 8'h3C, 1'b0, 1'b1, "rd10hold"};

    RESET = 1'b0; READ = 1'b0; WRITE = 1'b0; ADDRESS = 8'h00; WRITEDATA = 8'h00;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    chk("rst busywait", BUSYWAIT, 0);
    chk("rst readdata", READDATA, 8'h00);
    READ = 1'b1;
    #1;
    chk("rst busywait comb", BUSYWAIT, 1);
    READ = 1'b0;
    #1;
    chk("rst busywait drop", BUSYWAIT, 0);
    RESET = 1'b1;
    @(posedge CLK); #1;

    for (int i = 0; i < 12; i++) run_access(tbl[i]);

    // Reset lands in the third ACCESS cycle of a write to 8'h40.
    READ = 1'b0; WRITE = 1'b1; ADDRESS = 8'h40; WRITEDATA = 8'hFF;
    repeat (3) begin
      @(posedge CLK); #1;
    end
    chk("midrst access busy", BUSYWAIT, 1);
    RESET = 1'b0; WRITE = 1'b0;
    @(posedge CLK); #1;
    RESET = 1'b1;
    model_reset();
    chk("midrst busywait", BUSYWAIT, 0);
    chk("midrst readdata", READDATA, 8'h00);
    rv = '{1'b1, 1'b0, 8'h40, 8'h00, 8'h00, 1'b0, 1'b0, "rd40post"};
    run_access(rv);
    rv = '{1'b1, 1'b0, 8'h10, 8'h00, 8'h00, 1'b0, 1'b0, "rd10post"};
    run_access(rv);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
